// File: rtl/mem_port_arbiter.sv
// ============================================================================
// mem_port_arbiter : shares one single-port memory between fetch and data path
// Revision: 1.0
// ============================================================================
`default_nettype none

module mem_port_arbiter #(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int MEM_LAT    = 1,
   parameter int MAX_STREAK = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_ack,
   output logic [DATA_W-1:0] if_rdata,
   input  logic              d_req,
   input  logic              d_wr,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              d_ack,
   output logic [DATA_W-1:0] d_rdata,
   output logic              mem_enable,
   output logic              mem_wr,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_data_in,
   input  logic [DATA_W-1:0] mem_data_out,
   output logic              busy
);

   localparam int LAT_W = $clog2(MEM_LAT + 1);
   localparam int STR_W = $clog2(MAX_STREAK + 1);

   localparam logic [LAT_W-1:0] LAT_INIT   = LAT_W'(MEM_LAT);
   localparam logic [LAT_W-1:0] LAT_LAST   = LAT_W'(1);
   localparam logic [STR_W-1:0] STREAK_MAX = STR_W'(MAX_STREAK);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ISSUE = 2'd1;
   localparam logic [1:0] ST_WAIT  = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   logic [1:0]        state_q,    state_d;
   logic              owner_q,    owner_d;     // 1 = data port owns the access
   logic              wr_q,       wr_d;
   logic [ADDR_W-1:0] addr_q,     addr_d;
   logic [DATA_W-1:0] wdata_q,    wdata_d;
   logic [LAT_W-1:0]  lat_q,      lat_d;
   logic [STR_W-1:0]  streak_q,   streak_d;
   logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
   logic [DATA_W-1:0] d_rdata_q,  d_rdata_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         owner_q    <= 1'b0;
         wr_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         lat_q      <= '0;
         streak_q   <= '0;
         if_rdata_q <= '0;
         d_rdata_q  <= '0;
      end else begin
         state_q    <= state_d;
         owner_q    <= owner_d;
         wr_q       <= wr_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         lat_q      <= lat_d;
         streak_q   <= streak_d;
         if_rdata_q <= if_rdata_d;
         d_rdata_q  <= d_rdata_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      owner_d    = owner_q;
      wr_d       = wr_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      lat_d      = lat_q;
      streak_d   = streak_q;
      if_rdata_d = if_rdata_q;
      d_rdata_d  = d_rdata_q;
      case (state_q)
         ST_IDLE: begin
            // Data wins unless it has already taken MAX_STREAK contended grants in a row
            if (d_req && (!if_req || (streak_q < STREAK_MAX))) begin
               state_d = ST_ISSUE;
               owner_d = 1'b1;
               wr_d    = d_wr;
               addr_d  = d_addr;
               wdata_d = d_wdata;
               if (!if_req)
                  streak_d = '0;
               else if (streak_q != STREAK_MAX)
                  streak_d = streak_q + STR_W'(1);
            end else if (if_req) begin
               state_d  = ST_ISSUE;
               owner_d  = 1'b0;
               wr_d     = 1'b0;
               addr_d   = if_addr;
               streak_d = '0;
            end
         end
         ST_ISSUE: begin
            state_d = ST_WAIT;
            lat_d   = LAT_INIT;
         end
         ST_WAIT: begin
            if (lat_q == LAT_LAST) begin
               state_d = ST_DONE;
               if (!wr_q) begin
                  if (owner_q)
                     d_rdata_d = mem_data_out;
                  else
                     if_rdata_d = mem_data_out;
               end
            end else begin
               lat_d = lat_q - LAT_W'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_comb begin
      mem_enable = 1'b0;
      mem_wr     = 1'b0;
      if_ack     = 1'b0;
      d_ack      = 1'b0;
      busy       = (state_q != ST_IDLE);
      case (state_q)
         ST_ISSUE: begin
            mem_enable = 1'b1;
            mem_wr     = wr_q;
         end
         ST_DONE: begin
            if_ack = ~owner_q;
            d_ack  = owner_q;
         end
         default: begin
            mem_enable = 1'b0;
         end
      endcase
   end

   assign mem_addr    = addr_q;
   assign mem_data_in = wdata_q;
   assign if_rdata    = if_rdata_q;
   assign d_rdata     = d_rdata_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ============================================================================
// tb_mem_port_arbiter : directed scoreboard bench for mem_port_arbiter
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_req, d_req, d_wr;
   logic [31:0] if_addr, d_addr, d_wdata;
   logic        if_ack, d_ack, mem_enable, mem_wr, busy;
   logic [31:0] if_rdata, d_rdata, mem_addr, mem_data_in, mem_data_out;

   logic        if_req3, d_req3, d_wr3;
   logic [31:0] if_addr3, d_addr3, d_wdata3;
   logic        if_ack3, d_ack3, mem_enable3, mem_wr3, busy3;
   logic [31:0] if_rdata3, d_rdata3, mem_addr3, mem_data_in3, mem_data_out3;

   int vectors = 0;
   int miscompares = 0;

   typedef struct {
      bit          is_d;
      logic [31:0] rdata;
   } sb_t;
   sb_t sb[$];

   logic [31:0] rd_q;
   logic [31:0] rd3_q [3];

   always #5 clk = ~clk;

   mem_port_arbiter u_dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
      .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_ack(d_ack), .d_rdata(d_rdata),
      .mem_enable(mem_enable), .mem_wr(mem_wr), .mem_addr(mem_addr),
      .mem_data_in(mem_data_in), .mem_data_out(mem_data_out), .busy(busy)
   );

   mem_port_arbiter #(.MEM_LAT(3)) u_dut3 (
      .clk(clk), .rst(rst),
      .if_req(if_req3), .if_addr(if_addr3), .if_ack(if_ack3), .if_rdata(if_rdata3),
      .d_req(d_req3), .d_wr(d_wr3), .d_addr(d_addr3), .d_wdata(d_wdata3),
      .d_ack(d_ack3), .d_rdata(d_rdata3),
      .mem_enable(mem_enable3), .mem_wr(mem_wr3), .mem_addr(mem_addr3),
      .mem_data_in(mem_data_in3), .mem_data_out(mem_data_out3), .busy(busy3)
   );

   function automatic logic [31:0] mem_val(input logic [31:0] a);
      if (a == 32'h10)
         return 32'hDEADBEEF;
      return 32'hC0DE0000 | {16'h0, a[15:0]};
   endfunction

   // Memory models: read data appears MEM_LAT cycles after the enable cycle, X otherwise
   always @(posedge clk) begin
      rd_q     <= (mem_enable && !mem_wr) ? mem_val(mem_addr) : 'x;
      rd3_q[0] <= (mem_enable3 && !mem_wr3) ? mem_val(mem_addr3) : 'x;
      rd3_q[1] <= rd3_q[0];
      rd3_q[2] <= rd3_q[1];
   end
   assign mem_data_out  = rd_q;
   assign mem_data_out3 = rd3_q[2];

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic push(input bit is_d, input logic [31:0] rdata);
      sb_t e;
      e.is_d  = is_d;
      e.rdata = rdata;
      sb.push_back(e);
   endtask

   task automatic wait_ack(input int budget, output bit got, output bit is_d);
      got  = 1'b0;
      is_d = 1'b0;
      for (int i = 0; i < budget; i++) begin
         tick();
         if (if_ack || d_ack) begin
            got  = 1'b1;
            is_d = d_ack;
            break;
         end
      end
   endtask

   always @(negedge clk) begin
      if (!rst && (if_ack || d_ack)) begin
         check("ack_exclusive", {63'h0, if_ack & d_ack}, 64'h0);
         if (sb.size() == 0) begin
            vectors++;
            miscompares++;
            $error("FAIL sb_unexpected_ack observed=if_ack:%0b/d_ack:%0b expected=none", if_ack, d_ack);
         end else begin
            sb_t e;
            e = sb.pop_front();
            check("sb_port", {63'h0, d_ack}, {63'h0, e.is_d});
            check("sb_rdata", {32'h0, e.is_d ? d_rdata : if_rdata}, {32'h0, e.rdata});
         end
      end
   end

   initial begin
      bit got, is_d;
      bit exp_order [10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};

      rst = 1'b1;
      if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_wr = 1'b0; d_addr = '0; d_wdata = '0;
      if_req3 = 1'b0; if_addr3 = '0; d_req3 = 1'b0; d_wr3 = 1'b0; d_addr3 = '0; d_wdata3 = '0;
      tick(2);

      // reset state
      check("rst_mem_enable", {63'h0, mem_enable}, 64'h0);
      check("rst_mem_wr", {63'h0, mem_wr}, 64'h0);
      check("rst_mem_addr", {32'h0, mem_addr}, 64'h0);
      check("rst_mem_data_in", {32'h0, mem_data_in}, 64'h0);
      check("rst_acks", {62'h0, if_ack, d_ack}, 64'h0);
      check("rst_rdata", {if_rdata, d_rdata}, 64'h0);
      check("rst_busy", {63'h0, busy}, 64'h0);
      rst = 1'b0;
      tick();

      // fetch read of 0x10
      if_req = 1'b1; if_addr = 32'h10;
      push(1'b0, 32'hDEADBEEF);
      check("f_T_busy", {63'h0, busy}, 64'h0);
      tick();
      check("f_T1_issue", {61'h0, mem_enable, mem_wr, busy}, 64'b101);
      check("f_T1_addr", {32'h0, mem_addr}, 64'h10);
      tick();
      check("f_T2_wait", {60'h0, mem_enable, if_ack, d_ack, busy}, 64'b0001);
      tick();
      check("f_T3_done", {60'h0, mem_enable, if_ack, d_ack, busy}, 64'b0101);
      check("f_T3_rdata", {32'h0, if_rdata}, 64'hDEADBEEF);
      if_req = 1'b0;
      tick();
      check("f_T4_idle", {63'h0, busy}, 64'h0);

      // data write, d_rdata keeps its reset value
      d_req = 1'b1; d_wr = 1'b1; d_addr = 32'h20; d_wdata = 32'h1234;
      push(1'b1, 32'h0);
      tick();
      check("w_T1_strobes", {62'h0, mem_enable, mem_wr}, 64'b11);
      check("w_T1_bus", {mem_addr, mem_data_in}, {32'h20, 32'h1234});
      d_wdata = 32'hFFFF;
      tick();
      check("w_T2_strobes", {62'h0, mem_enable, mem_wr}, 64'b00);
      check("w_T2_data_held", {32'h0, mem_data_in}, 64'h1234);
      tick();
      check("w_T3_ack", {62'h0, if_ack, d_ack}, 64'b01);
      check("w_T3_d_rdata", {32'h0, d_rdata}, 64'h0);
      d_req = 1'b0; d_wr = 1'b0;
      tick();

      // contention: data first, then fetch
      d_req = 1'b1; d_addr = 32'h40; if_req = 1'b1; if_addr = 32'h50;
      push(1'b1, mem_val(32'h40));
      push(1'b0, mem_val(32'h50));
      tick();
      check("c_T1_addr", {32'h0, mem_addr}, 64'h40);
      tick(2);
      check("c_T3_ack", {62'h0, if_ack, d_ack}, 64'b01);
      check("c_T3_if_rdata_kept", {32'h0, if_rdata}, 64'hDEADBEEF);
      d_req = 1'b0;
      tick();
      check("c_T4_idle", {62'h0, busy, if_ack}, 64'b00);
      tick();
      check("c_T5_issue", {31'h0, mem_enable, mem_addr}, {31'h0, 1'b1, 32'h50});
      tick(2);
      check("c_T7_ack", {62'h0, if_ack, d_ack}, 64'b10);
      check("c_T7_rdata", {if_rdata, d_rdata}, {mem_val(32'h50), mem_val(32'h40)});
      if_req = 1'b0;
      tick();

      // streak limit under continuous contention
      d_req = 1'b1; d_addr = 32'h60; if_req = 1'b1; if_addr = 32'h70;
      for (int k = 0; k < 10; k++)
         push(exp_order[k], exp_order[k] ? mem_val(32'h60) : mem_val(32'h70));
      for (int k = 0; k < 10; k++) begin
         wait_ack(10, got, is_d);
         check("streak_ack_seen", {63'h0, got}, 64'h1);
         check("streak_order", {63'h0, is_d}, {63'h0, exp_order[k]});
      end
      d_req = 1'b0; if_req = 1'b0;
      tick();

      // reset during WAIT abandons the fetch, held req re-arbitrates
      if_req = 1'b1; if_addr = 32'h30;
      tick(2);
      rst = 1'b1;
      tick();
      check("r_T3_ctrl", {59'h0, mem_enable, mem_wr, if_ack, d_ack, busy}, 64'h0);
      check("r_T3_bus", {mem_addr, mem_data_in}, 64'h0);
      check("r_T3_rdata", {if_rdata, d_rdata}, 64'h0);
      rst = 1'b0;
      push(1'b0, mem_val(32'h30));
      tick();
      check("r_T4_issue", {30'h0, if_ack, mem_enable, mem_addr}, {30'h0, 2'b01, 32'h30});
      tick(2);
      check("r_T6_ack", {62'h0, if_ack, d_ack}, 64'b10);
      if_req = 1'b0;
      tick();

      // MEM_LAT=3 instance
      d_req3 = 1'b1; d_addr3 = 32'h44;
      tick();
      check("l3_T1_issue", {62'h0, mem_enable3, busy3}, 64'b11);
      tick();
      check("l3_T2_wait", {62'h0, mem_enable3, busy3}, 64'b01);
      tick(2);
      check("l3_T4_noack", {62'h0, d_ack3, busy3}, 64'b01);
      tick();
      check("l3_T5_ack", {62'h0, if_ack3, d_ack3}, 64'b01);
      check("l3_T5_rdata", {32'h0, d_rdata3}, {32'h0, mem_val(32'h44)});
      d_req3 = 1'b0;
      tick();
      check("l3_T6_idle", {63'h0, busy3}, 64'h0);

      check("sb_drained", 64'(sb.size()), 64'h0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

`default_nettype wire
